// File: rtl/fw_loader_if.sv
// Byte-stream input and memory write port of the boot-image loader.
interface fw_loader_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned REG_WIDTH  = 8
);
  logic [REG_WIDTH-1:0]  in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_dout;
  logic                  mem_we;

  // Loader side: consumes the stream and drives the memory write port.
  modport master (
    input  in_data, in_valid, in_last,
    output in_ready, mem_addr, mem_dout, mem_we
  );

  // Environment side: stream source and memory.
  modport slave (
    output in_data, in_valid, in_last,
    input  in_ready, mem_addr, mem_dout, mem_we
  );
endinterface

// File: rtl/fw_loader.sv
// Streams a program image into memory at BASE_ADDR, writes the 6502 reset
// vector, then holds the CPU in reset for HOLD_CYCLES before releasing it.
module fw_loader #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           REG_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(16'h0200),
  parameter int unsigned           MAX_SIZE    = 1024,
  parameter int unsigned           HOLD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  fw_loader_if.master           bus,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] byte_count
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] VEC_LO_ADDR = ADDR_WIDTH'(16'hFFFC);
  localparam logic [ADDR_WIDTH-1:0] VEC_HI_ADDR = ADDR_WIDTH'(16'hFFFD);
  localparam logic [ADDR_WIDTH-1:0] LAST_COUNT  = ADDR_WIDTH'(MAX_SIZE);
  localparam logic [HOLD_W-1:0]     HOLD_LOAD   = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_VEC_LO, S_VEC_HI, S_HOLD, S_RUN, S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  dout_q, dout_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  accept;

  assign accept = bus.in_valid && in_ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      dout_q      <= '0;
      we_q        <= 1'b0;
      count_q     <= '0;
      hold_q      <= '0;
      cpu_rst_n_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      we_q        <= we_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    we_d        = 1'b0;
    count_d     = count_q;
    hold_d      = hold_q;
    cpu_rst_n_d = 1'b0;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          addr_d  = BASE_ADDR + count_q;
          dout_d  = bus.in_data;
          we_d    = 1'b1;
          count_d = count_q + ADDR_WIDTH'(1);
          // in_last wins over the size limit on the final permitted byte
          if (bus.in_last)                 state_d = S_VEC_LO;
          else if (count_d == LAST_COUNT)  state_d = S_ERR;
        end
      end
      S_VEC_LO: begin
        addr_d  = VEC_LO_ADDR;
        dout_d  = REG_WIDTH'(BASE_ADDR);
        we_d    = 1'b1;
        state_d = S_VEC_HI;
      end
      S_VEC_HI: begin
        addr_d  = VEC_HI_ADDR;
        dout_d  = REG_WIDTH'(BASE_ADDR >> 8);
        we_d    = 1'b1;
        hold_d  = HOLD_LOAD;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) state_d = S_RUN;
      end
      S_RUN: begin
        // Release is registered one edge after entering RUN; a restart pulls it low at once
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
        end else begin
          cpu_rst_n_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_VEC_LO) ||
                 (state_d == S_VEC_HI) || (state_d == S_HOLD);
    done_d     = (state_d == S_RUN);
    error_d    = (state_d == S_ERR);
  end

  assign bus.in_ready = in_ready_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_dout = dout_q;
  assign bus.mem_we   = we_q;
  assign cpu_reset_n  = cpu_rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign byte_count   = count_q;

endmodule

// File: tb/tb_fw_loader.sv
// Directed bench for fw_loader: main instance with default sizing plus a
// MAX_SIZE=4 instance for the overflow path.
module tb_fw_loader;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic start, start_ovf;
  logic cpu_reset_n, busy, done, error;
  logic cpu_reset_n_ovf, busy_ovf, done_ovf, error_ovf;
  logic [AW-1:0] byte_count, byte_count_ovf;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img [0:7];
  logic [15:0] log_a[$];
  logic [7:0]  log_d[$];
  logic [15:0] log_a_ovf[$];
  logic [7:0]  log_d_ovf[$];

  always #5 clk = ~clk;

  fw_loader_if #(.ADDR_WIDTH(AW), .REG_WIDTH(DW)) ifc ();
  fw_loader_if #(.ADDR_WIDTH(AW), .REG_WIDTH(DW)) ifc_ovf ();

  fw_loader #(.ADDR_WIDTH(AW), .REG_WIDTH(DW), .BASE_ADDR(16'h0200),
              .MAX_SIZE(1024), .HOLD_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(ifc),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .error(error),
    .byte_count(byte_count)
  );

  fw_loader #(.ADDR_WIDTH(AW), .REG_WIDTH(DW), .BASE_ADDR(16'h0200),
              .MAX_SIZE(4), .HOLD_CYCLES(8)) dut_ovf (
    .clk(clk), .reset_n(reset_n), .start(start_ovf), .bus(ifc_ovf),
    .cpu_reset_n(cpu_reset_n_ovf), .busy(busy_ovf), .done(done_ovf), .error(error_ovf),
    .byte_count(byte_count_ovf)
  );

  // Memory-port monitors: each posedge sees the write held during the cycle before it
  always @(posedge clk) begin
    if (ifc.mem_we === 1'b1) begin
      log_a.push_back(ifc.mem_addr);
      log_d.push_back(ifc.mem_dout);
    end
    if (ifc_ovf.mem_we === 1'b1) begin
      log_a_ovf.push_back(ifc_ovf.mem_addr);
      log_d_ovf.push_back(ifc_ovf.mem_dout);
    end
  end

  function automatic logic [15:0] exp_addr(input int i, input int n);
    if (i < n) return 16'h0200 + 16'(i);
    return (i == n) ? 16'hFFFC : 16'hFFFD;
  endfunction

  function automatic logic [7:0] exp_data(input int i, input int n);
    if (i < n) return img[i];
    return (i == n) ? 8'h00 : 8'h02;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends img[first..n-1]; gappy mode asserts in_valid on every third cycle
  // and raises in_last during the gaps, which must be ignored.
  task automatic send(input int first, input int n, input bit gappy, input bit mark_last);
    int  sent;
    int  c;
    bit  v;
    sent = first;
    c = 0;
    while (sent < n) begin
      v = !gappy || (c % 3 == 0);
      ifc.in_valid = v;
      ifc.in_data  = v ? img[sent] : 8'hFF;
      ifc.in_last  = v ? (mark_last && sent == n - 1) : 1'b1;
      @(negedge clk);
      checks++;
      if (ifc.mem_we !== v) begin
        errors++;
        $display("FAIL send_we cycle %0d: got %b exp %b", c, ifc.mem_we, v);
      end
      if (v) begin
        checks++;
        if (ifc.mem_addr !== 16'h0200 + 16'(sent) || ifc.mem_dout !== img[sent]) begin
          errors++;
          $display("FAIL send_write byte %0d: got %h/%h exp %h/%h", sent,
                   ifc.mem_addr, ifc.mem_dout, 16'h0200 + 16'(sent), img[sent]);
        end
        sent++;
      end
      c++;
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc.in_ready, ifc.mem_we, cpu_reset_n, busy, done, error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 000000",
               {ifc.in_ready, ifc.mem_we, cpu_reset_n, busy, done, error});
    end
    checks++;
    if (ifc.mem_addr !== 16'h0 || ifc.mem_dout !== 8'h0 || byte_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h/%h/%h exp 0000/00/0000",
               ifc.mem_addr, ifc.mem_dout, byte_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    log_a.delete(); log_d.delete();
    pulse_start();
    checks++;
    if (ifc.in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready: got %b/%b exp 1/1", ifc.in_ready, busy);
    end
    send(0, 5, 1'b0, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (ifc.mem_we !== 1'b1 || ifc.mem_addr !== 16'hFFFC || ifc.mem_dout !== 8'h00) begin
          errors++;
          $display("FAIL basic_vec_lo: got %b %h %h exp 1 fffc 00", ifc.mem_we, ifc.mem_addr, ifc.mem_dout);
        end
      end
      if (k == 2) begin
        checks++;
        if (ifc.mem_we !== 1'b1 || ifc.mem_addr !== 16'hFFFD || ifc.mem_dout !== 8'h02) begin
          errors++;
          $display("FAIL basic_vec_hi: got %b %h %h exp 1 fffd 02", ifc.mem_we, ifc.mem_addr, ifc.mem_dout);
        end
      end
      if (k == 3) begin
        checks++;
        if (ifc.mem_we !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_hold: got we %b busy %b exp 0 1", ifc.mem_we, busy);
        end
      end
      if (k == 10) begin
        checks++;
        if (cpu_reset_n !== 1'b0 || done !== 1'b1) begin
          errors++;
          $display("FAIL basic_pre_release: got cpu %b done %b exp 0 1", cpu_reset_n, done);
        end
      end
      if (k == 11) begin
        checks++;
        if (cpu_reset_n !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL basic_release: got cpu %b done %b busy %b exp 1 1 0", cpu_reset_n, done, busy);
        end
      end
    end
    checks++;
    if (byte_count !== 16'd5 || log_a.size() != 7) begin
      errors++;
      $display("FAIL basic_count: got bc %0d writes %0d exp 5 7", byte_count, log_a.size());
    end
    for (int i = 0; i < 7 && i < log_a.size(); i++) begin
      checks++;
      if (log_a[i] !== exp_addr(i, 5) || log_d[i] !== exp_data(i, 5)) begin
        errors++;
        $display("FAIL basic_log[%0d]: got %h=%h exp %h=%h", i, log_a[i], log_d[i], exp_addr(i, 5), exp_data(i, 5));
      end
    end
  endtask

  task automatic test_gappy();
    int k;
    log_a.delete(); log_d.delete();
    pulse_start();
    checks++;
    if (cpu_reset_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || byte_count !== 16'd0) begin
      errors++;
      $display("FAIL run_restart: got cpu %b busy %b done %b bc %0d exp 0 1 0 0",
               cpu_reset_n, busy, done, byte_count);
    end
    send(0, 5, 1'b1, 1'b1);
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 10) begin
      errors++;
      $display("FAIL gappy_done_latency: got %0d exp 10", k);
    end
    @(negedge clk);
    checks++;
    if (cpu_reset_n !== 1'b1 || log_a.size() != 7) begin
      errors++;
      $display("FAIL gappy_release: got cpu %b writes %0d exp 1 7", cpu_reset_n, log_a.size());
    end
    for (int i = 0; i < 7 && i < log_a.size(); i++) begin
      checks++;
      if (log_a[i] !== exp_addr(i, 5) || log_d[i] !== exp_data(i, 5)) begin
        errors++;
        $display("FAIL gappy_log[%0d]: got %h=%h exp %h=%h", i, log_a[i], log_d[i], exp_addr(i, 5), exp_data(i, 5));
      end
    end
  endtask

  task automatic test_start_busy();
    int k;
    pulse_start();
    send(0, 2, 1'b0, 1'b0);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || ifc.in_ready !== 1'b1 || byte_count !== 16'd2) begin
      errors++;
      $display("FAIL start_in_load: got busy %b rdy %b bc %0d exp 1 1 2", busy, ifc.in_ready, byte_count);
    end
    send(2, 5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || ifc.in_ready !== 1'b0 || byte_count !== 16'd5) begin
      errors++;
      $display("FAIL start_in_hold: got busy %b done %b rdy %b bc %0d exp 1 0 0 5",
               busy, done, ifc.in_ready, byte_count);
    end
    k = 0;
    while (cpu_reset_n !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 6) begin
      errors++;
      $display("FAIL hold_release_latency: got %0d exp 6", k);
    end
  endtask

  task automatic test_reset_mid_load();
    int k;
    pulse_start();
    send(0, 2, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (ifc.mem_we !== 1'b0 || cpu_reset_n !== 1'b0 || byte_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got we %b cpu %b bc %0d busy %b exp 0 0 0 0",
               ifc.mem_we, cpu_reset_n, byte_count, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    log_a.delete(); log_d.delete();
    pulse_start();
    send(0, 5, 1'b0, 1'b1);
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done !== 1'b1 || log_a.size() != 7 || log_a[0] !== 16'h0200) begin
      errors++;
      $display("FAIL reload_after_reset: got done %b writes %0d first %h exp 1 7 0200",
               done, log_a.size(), log_a[0]);
    end
  endtask

  task automatic test_single();
    int k;
    img[0] = 8'hEA;
    log_a.delete(); log_d.delete();
    pulse_start();
    send(0, 1, 1'b0, 1'b1);
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (byte_count !== 16'd1 || log_a.size() != 3 || done !== 1'b1) begin
      errors++;
      $display("FAIL single_count: got bc %0d writes %0d done %b exp 1 3 1", byte_count, log_a.size(), done);
    end
    for (int i = 0; i < 3 && i < log_a.size(); i++) begin
      checks++;
      if (log_a[i] !== exp_addr(i, 1) || log_d[i] !== exp_data(i, 1)) begin
        errors++;
        $display("FAIL single_log[%0d]: got %h=%h exp %h=%h", i, log_a[i], log_d[i], exp_addr(i, 1), exp_data(i, 1));
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    log_a_ovf.delete(); log_d_ovf.delete();
    start_ovf = 1'b1;
    @(negedge clk);
    start_ovf = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ifc_ovf.in_valid = 1'b1;
      ifc_ovf.in_last  = 1'b0;
      ifc_ovf.in_data  = 8'h10 + 8'(i);
      @(negedge clk);
    end
    ifc_ovf.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (error_ovf !== 1'b1 || ifc_ovf.in_ready !== 1'b0 || cpu_reset_n_ovf !== 1'b0 || busy_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_state: got err %b rdy %b cpu %b busy %b exp 1 0 0 0",
               error_ovf, ifc_ovf.in_ready, cpu_reset_n_ovf, busy_ovf);
    end
    checks++;
    if (log_a_ovf.size() != 4 || byte_count_ovf !== 16'd4) begin
      errors++;
      $display("FAIL ovf_count: got writes %0d bc %0d exp 4 4", log_a_ovf.size(), byte_count_ovf);
    end
    for (int i = 0; i < 4 && i < log_a_ovf.size(); i++) begin
      b = 8'h10 + 8'(i);
      checks++;
      if (log_a_ovf[i] !== 16'h0200 + 16'(i) || log_d_ovf[i] !== b) begin
        errors++;
        $display("FAIL ovf_log[%0d]: got %h=%h exp %h=%h", i, log_a_ovf[i], log_d_ovf[i], 16'h0200 + 16'(i), b);
      end
    end
    start_ovf = 1'b1;
    @(negedge clk);
    start_ovf = 1'b0;
    checks++;
    if (error_ovf !== 1'b0 || ifc_ovf.in_ready !== 1'b1 || byte_count_ovf !== 16'd0) begin
      errors++;
      $display("FAIL ovf_retry: got err %b rdy %b bc %0d exp 0 1 0", error_ovf, ifc_ovf.in_ready, byte_count_ovf);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    start_ovf = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_last = 1'b0; ifc.in_data = 8'h00;
    ifc_ovf.in_valid = 1'b0; ifc_ovf.in_last = 1'b0; ifc_ovf.in_data = 8'h00;
    img[0] = 8'hA9; img[1] = 8'h05; img[2] = 8'h8D; img[3] = 8'h00;
    img[4] = 8'h02; img[5] = 8'h00; img[6] = 8'h00; img[7] = 8'h00;
    test_reset();
    test_basic();
    test_gappy();
    test_start_busy();
    test_reset_mid_load();
    test_single();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
